// File: rtl/udma_clkdiv_req.sv
// udma_clkdiv_req: register-domain side of the clock-divider 4-phase handshake,
// with a one-deep last-write-wins queue and a committed-value readback.
module udma_clkdiv_req #(
    parameter int DIV_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             cfg_we_i,
    output logic [DIV_W-1:0] clk_div_data_o,
    output logic             clk_div_valid_o,
    input  logic             clk_div_ack_i,
    output logic             busy_o,
    output logic             pending_o,
    output logic             done_o,
    output logic [DIV_W-1:0] cfg_div_cur_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, REL = 2'd2} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [DIV_W-1:0]       shadow;
    logic                   ack_s;
    logic                   start;
    logic [DIV_W-1:0]       next_data;

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign start     = cfg_we_i || pending_o;
    assign next_data = cfg_we_i ? cfg_div_i : shadow;
    assign busy_o    = state != IDLE;

    // valid is a dedicated flop so the level crossing domains never glitches on state decode
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= IDLE;
            ack_sync        <= '0;
            shadow          <= '0;
            pending_o       <= 1'b0;
            clk_div_data_o  <= '0;
            clk_div_valid_o <= 1'b0;
            done_o          <= 1'b0;
            cfg_div_cur_o   <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], clk_div_ack_i};
            done_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ack_s) begin
                        if (cfg_we_i) begin
                            shadow    <= cfg_div_i;
                            pending_o <= 1'b1;
                        end
                    end else if (start) begin
                        clk_div_data_o  <= next_data;
                        pending_o       <= 1'b0;
                        clk_div_valid_o <= 1'b1;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (cfg_we_i) begin
                        shadow    <= cfg_div_i;
                        pending_o <= 1'b1;
                    end
                    if (ack_s) begin
                        cfg_div_cur_o   <= clk_div_data_o;
                        clk_div_valid_o <= 1'b0;
                        state           <= REL;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        done_o <= 1'b1;
                        if (start) begin
                            clk_div_data_o  <= next_data;
                            pending_o       <= 1'b0;
                            clk_div_valid_o <= 1'b1;
                            state           <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cfg_we_i) begin
                        shadow    <= cfg_div_i;
                        pending_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udma_clkdiv_req.sv
// tb_udma_clkdiv_req: directed checks of the divider request handshake plus a
// randomized-ack stability run.
module tb_udma_clkdiv_req;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] cfg_div = '0;
    logic       cfg_we = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       ack = 1'b0;
    logic       busy;
    logic       pending;
    logic       done;
    logic [7:0] cur;

    int   errs = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   sent = 0;
    logic prev_valid = 1'b0;
    logic [7:0] prev_data = '0;
    logic seen_10 = 1'b0;
    logic auto_ack = 1'b0;

    udma_clkdiv_req #(.DIV_W(8), .SYNC_STAGES(2)) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .cfg_div_i(cfg_div),
        .cfg_we_i(cfg_we),
        .clk_div_data_o(data),
        .clk_div_valid_o(valid),
        .clk_div_ack_i(ack),
        .busy_o(busy),
        .pending_o(pending),
        .done_o(done),
        .cfg_div_cur_o(cur)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write(input logic [7:0] v);
        cfg_div = v;
        cfg_we  = 1'b1;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic wait_valid(input logic lvl);
        int n = 0;
        while (valid !== lvl && n < 100) begin
            tick();
            n++;
        end
        check("wait_valid", valid, lvl);
    endtask

    task automatic ack_hi();
        ack = 1'b1;
        wait_valid(1'b0);
    endtask

    task automatic ack_lo();
        int n = 0;
        ack = 1'b0;
        tick();
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("wait_done", done, 1'b1);
    endtask

    task automatic pulse_reset();
        #2 rstn = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
    endtask

    // Outputs move only at posedge (or on async reset), so negedge sampling is race-free.
    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (done) done_cnt++;
            if (valid && !prev_valid) sent++;
            if (valid && data == 8'h10) seen_10 = 1'b1;
            if (data != prev_data) check("data_hold", valid && !prev_valid, 1'b1);
        end
        prev_valid = valid;
        prev_data  = data;
    end

    initial forever begin
        @(negedge clk);
        if (auto_ack) begin
            if (valid && !ack) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                ack = 1'b1;
            end else if (!valid && ack) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                ack = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, s0, n;
        logic [7:0] last_wr;
        tick();
        check("rst_valid", valid, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_pending", pending, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cur", cur, 8'h00);
        #2 rstn = 1'b1;
        tick();

        // single write
        d0 = done_cnt;
        write(8'h05);
        check("t1_valid", valid, 1'b1);
        check("t1_data", data, 8'h05);
        check("t1_busy", busy, 1'b1);
        repeat (3) tick();
        ack = 1'b1;
        tick();
        tick();
        check("t1_still_req", valid, 1'b1);
        tick();
        check("t1_rel_valid", valid, 1'b0);
        check("t1_cur", cur, 8'h05);
        check("t1_rel_data", data, 8'h05);
        ack = 1'b0;
        tick();
        tick();
        check("t1_no_done_yet", done, 1'b0);
        tick();
        check("t1_done", done, 1'b1);
        check("t1_idle", busy, 1'b0);
        tick();
        check("t1_done_once", done, 1'b0);
        check("t1_done_cnt", done_cnt - d0, 1);

        // queued overwrite: only the last queued value is sent
        d0 = done_cnt;
        seen_10 = 1'b0;
        write(8'h05);
        write(8'h10);
        write(8'h22);
        check("t2_pending", pending, 1'b1);
        check("t2_data1", data, 8'h05);
        ack_hi();
        check("t2_cur1", cur, 8'h05);
        ack_lo();
        check("t2_b2b_valid", valid, 1'b1);
        check("t2_data2", data, 8'h22);
        check("t2_pending_clr", pending, 1'b0);
        ack_hi();
        check("t2_cur2", cur, 8'h22);
        ack_lo();
        check("t2_idle", busy, 1'b0);
        check("t2_done_cnt", done_cnt - d0, 2);
        check("t2_no_10", seen_10, 1'b0);

        // write coinciding with REL completion launches directly
        d0 = done_cnt;
        write(8'h30);
        ack_hi();
        ack = 1'b0;
        tick();
        tick();
        check("t3_pre_done", done, 1'b0);
        cfg_div = 8'h33;
        cfg_we  = 1'b1;
        tick();
        cfg_we  = 1'b0;
        check("t3_done", done, 1'b1);
        check("t3_valid", valid, 1'b1);
        check("t3_data", data, 8'h33);
        check("t3_busy", busy, 1'b1);
        check("t3_pending", pending, 1'b0);
        ack_hi();
        check("t3_cur", cur, 8'h33);
        ack_lo();
        check("t3_done_cnt", done_cnt - d0, 2);

        // stale ack out of reset
        ack = 1'b1;
        pulse_reset();
        repeat (4) tick();
        write(8'h07);
        check("t4_valid_low", valid, 1'b0);
        check("t4_pending", pending, 1'b1);
        check("t4_busy", busy, 1'b0);
        ack = 1'b0;
        tick();
        tick();
        check("t4_wait", valid, 1'b0);
        tick();
        check("t4_valid", valid, 1'b1);
        check("t4_data", data, 8'h07);
        ack_hi();
        ack_lo();
        check("t4_cur", cur, 8'h07);

        // reset mid-handshake
        write(8'h44);
        write(8'h55);
        check("t5_pending", pending, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("t5_valid", valid, 1'b0);
        check("t5_data", data, 8'h00);
        check("t5_busy", busy, 1'b0);
        check("t5_pending0", pending, 1'b0);
        check("t5_cur", cur, 8'h00);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        tick();
        check("t5_lost_queue", valid, 1'b0);
        write(8'h02);
        check("t5_data2", data, 8'h02);
        ack_hi();
        ack_lo();
        check("t5_cur2", cur, 8'h02);
        check("t5_idle", busy, 1'b0);

        // random writes against random ack delays
        d0 = done_cnt;
        s0 = sent;
        last_wr = cur;
        auto_ack = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                last_wr = 8'($urandom_range(0, 255));
                write(last_wr);
            end else begin
                tick();
            end
        end
        n = 0;
        while ((busy || pending || ack) && n < 2000) begin
            tick();
            n++;
        end
        check("t6_quiesce", busy || pending || ack, 1'b0);
        auto_ack = 1'b0;
        check("t6_done_eq_sent", done_cnt - d0, sent - s0);
        check("t6_some_sent", (sent - s0) > 0, 1'b1);
        check("t6_cur_last", cur, last_wr);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
